// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match, pointer-then-data writes and auto-incrementing burst reads.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 16,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  input  logic          sda,
  output logic          sda_drive_en,
  output logic [3:0]    state,
  output logic          busy,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic            drive_q, drive_d;
  logic            rw_q, rw_d;
  logic            phase_q, phase_d;
  logic [7:0]      mem_q [NUM_REGS];
  logic            wr_en;
  logic [7:0]      wr_data;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
  assign stop_det  = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;
  assign byte_in   = {shift_q[6:0], sda_s2_q};
  assign rd_byte   = mem_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    drive_d   = drive_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    wr_en     = 1'b0;
    wr_data   = byte_in;

    if (stop_det) begin
      state_d = S_IDLE;
      drive_d = 1'b0;
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      drive_d   = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == TARGET_ADDR) begin
                  busy_d  = 1'b1;
                  rw_d    = byte_in[0];
                  state_d = S_ADDR_ACK;
                end else begin
                  state_d = S_IDLE;
                end
              end else if (state_q == S_PTR) begin
                ptr_d   = byte_in[AW-1:0];
                state_d = S_PTR_ACK;
              end else begin
                wr_en   = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                state_d = S_WDATA_ACK;
              end
            end
          end
        end
        // First fall after the byte pulls SDA low; the fall after the 9th clock releases it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              drive_d = 1'b1;
              phase_d = 1'b1;
            end else begin
              drive_d   = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d = S_RDATA;
                drive_d = ~rd_byte[7];
                shift_d = {rd_byte[6:0], 1'b0};
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_PTR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        // bit_cnt counts falls after bit 7 went out; the 8th fall ends the byte.
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              drive_d   = 1'b0;
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = 3'd0;
              phase_d   = 1'b0;
              state_d   = S_RDATA_ACK;
            end else begin
              drive_d   = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s2_q) state_d = S_IDLE;
            else          phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            state_d   = S_RDATA;
            drive_d   = ~rd_byte[7];
            shift_d   = {rd_byte[6:0], 1'b0};
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          drive_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      drive_q   <= 1'b0;
      rw_q      <= 1'b0;
      phase_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      drive_q   <= drive_d;
      rw_q      <= rw_d;
      phase_q   <= phase_d;
      if (wr_en) mem_q[ptr_q] <= wr_data;
    end
  end

  assign sda_drive_en = drive_q;
  assign state        = state_q;
  assign busy         = busy_q;
  assign host_rdata   = mem_q[host_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master on a wired-AND SDA, table of bus
// transactions with expected ACKs/data, plus a hand-written mid-transfer reset sequence.
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_w;
  logic       sda_drive_en;
  logic [3:0] state;
  logic       busy;
  logic [3:0] host_addr;
  logic [7:0] host_rdata;

  assign sda_w = sda_m & ~sda_drive_en;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .NUM_REGS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .scl          (scl_m),
    .sda          (sda_w),
    .sda_drive_en (sda_drive_en),
    .state        (state),
    .busy         (busy),
    .host_addr    (host_addr),
    .host_rdata   (host_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int OP_START = 0;
  localparam int OP_STOP  = 1;
  localparam int OP_WR    = 2;  // exp[0] = ACK bit seen by the master
  localparam int OP_RD    = 3;  // data[0] = master ACK bit, exp = byte returned
  localparam int OP_REG   = 4;  // data = host_addr, exp = host_rdata
  localparam int OP_STATE = 5;
  localparam int OP_BUSY  = 6;

  typedef struct {
    int         op;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int op, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.op = op; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts and ends with SCL just pulled low: 8 clk low, 8 clk high.
  task automatic bit_cycle(input logic b, output logic s, output logic d);
    wclk(4); sda_m = b;
    wclk(4); scl_m = 1'b1;
    wclk(4); s = sda_w; d = sda_drive_en;
    wclk(4); scl_m = 1'b0;
  endtask

  task automatic start_c();
    wclk(4); sda_m = 1'b1;
    wclk(4); scl_m = 1'b1;
    wclk(8); sda_m = 1'b0;
    wclk(8); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wclk(4); sda_m = 1'b0;
    wclk(4); scl_m = 1'b1;
    wclk(8); sda_m = 1'b1;
    wclk(8);
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack);
    logic s, d;
    for (int i = 7; i >= 0; i--) bit_cycle(v[i], s, d);
    bit_cycle(1'b1, ack, d);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] v, output logic d_ack);
    logic s, d;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s, d);
      v = {v[6:0], s};
    end
    bit_cycle(mack, s, d_ack);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, d, s;
    logic [7:0] v;

    // Write reg3, then check state/busy after STOP
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA0, 8'h00);
    add(OP_WR,    8'h03, 8'h00);
    add(OP_WR,    8'hA5, 8'h00);
    add(OP_STOP,  8'h00, 8'h00);
    add(OP_REG,   8'h03, 8'hA5);
    add(OP_STATE, 8'h00, 8'h00);
    add(OP_BUSY,  8'h00, 8'h00);
    // Pointer, repeated START, single read with NACK
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA0, 8'h00);
    add(OP_WR,    8'h03, 8'h00);
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA1, 8'h00);
    add(OP_RD,    8'h01, 8'hA5);
    add(OP_STATE, 8'h00, 8'h00);
    add(OP_BUSY,  8'h00, 8'h01);
    add(OP_STOP,  8'h00, 8'h00);
    add(OP_BUSY,  8'h00, 8'h00);
    // Pointer advanced to 4: a fresh read returns reg4
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA1, 8'h00);
    add(OP_RD,    8'h01, 8'h00);
    add(OP_STOP,  8'h00, 8'h00);
    // Address mismatch, then a matching transaction
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'h42, 8'h01);
    add(OP_STATE, 8'h00, 8'h00);
    add(OP_BUSY,  8'h00, 8'h00);
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA0, 8'h00);
    add(OP_BUSY,  8'h00, 8'h01);
    add(OP_STOP,  8'h00, 8'h00);
    add(OP_BUSY,  8'h00, 8'h00);
    // reg14, then wrap-around write 15 -> 0
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA0, 8'h00);
    add(OP_WR,    8'h0E, 8'h00);
    add(OP_WR,    8'h5C, 8'h00);
    add(OP_STOP,  8'h00, 8'h00);
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA0, 8'h00);
    add(OP_WR,    8'h0F, 8'h00);
    add(OP_WR,    8'h11, 8'h00);
    add(OP_WR,    8'h22, 8'h00);
    add(OP_STOP,  8'h00, 8'h00);
    add(OP_REG,   8'h0E, 8'h5C);
    add(OP_REG,   8'h0F, 8'h11);
    add(OP_REG,   8'h00, 8'h22);
    // Burst read 14, 15, 0 with ACK, ACK, NACK
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA0, 8'h00);
    add(OP_WR,    8'h0E, 8'h00);
    add(OP_START, 8'h00, 8'h00);
    add(OP_WR,    8'hA1, 8'h00);
    add(OP_RD,    8'h00, 8'h5C);
    add(OP_RD,    8'h00, 8'h11);
    add(OP_RD,    8'h01, 8'h22);
    add(OP_STOP,  8'h00, 8'h00);
    add(OP_STATE, 8'h00, 8'h00);

    scl_m = 1'b1; sda_m = 1'b1; host_addr = 4'd0; rst = 1'b1;
    wclk(4);
    rst = 1'b0;
    wclk(4);
    check("reset_state", {4'b0, state}, 8'h00);
    check("reset_busy", {7'b0, busy}, 8'h00);
    check("reset_drive", {7'b0, sda_drive_en}, 8'h00);
    check("reset_reg0", host_rdata, 8'h00);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_START: start_c();
        OP_STOP:  stop_c();
        OP_WR: begin
          wbyte(vecs[i].data, a);
          check($sformatf("wr_ack[%0d] byte %02h", i, vecs[i].data), {7'b0, a}, vecs[i].exp);
        end
        OP_RD: begin
          rbyte(vecs[i].data[0], v, d);
          check($sformatf("rd_data[%0d]", i), v, vecs[i].exp);
          check($sformatf("rd_ack_release[%0d]", i), {7'b0, d}, 8'h00);
        end
        OP_REG: begin
          host_addr = vecs[i].data[3:0];
          wclk(1);
          check($sformatf("reg[%0d] addr %0d", i, vecs[i].data), host_rdata, vecs[i].exp);
        end
        OP_STATE: check($sformatf("state[%0d]", i), {4'b0, state}, vecs[i].exp);
        OP_BUSY:  check($sformatf("busy[%0d]", i), {7'b0, busy}, vecs[i].exp);
        default:  ;
      endcase
    end

    // Reset while the 4th data bit of a write to reg5 has SCL high
    start_c();
    wbyte(8'hA0, a);
    check("rst_seq_addr_ack", {7'b0, a}, 8'h00);
    wbyte(8'h05, a);
    check("rst_seq_ptr_ack", {7'b0, a}, 8'h00);
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, s, d);
    wclk(4); sda_m = 1'b1;
    wclk(4); scl_m = 1'b1;
    wclk(2); rst = 1'b1;
    wclk(1); rst = 1'b0;
    check("rst_mid_drive", {7'b0, sda_drive_en}, 8'h00);
    check("rst_mid_state", {4'b0, state}, 8'h00);
    wclk(5); scl_m = 1'b0;
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, s, d);
    bit_cycle(1'b1, a, d);
    check("rst_ignored_ack", {7'b0, a}, 8'h01);
    stop_c();
    host_addr = 4'd5;
    wclk(1);
    check("rst_reg5_unwritten", host_rdata, 8'h00);
    start_c();
    wbyte(8'hA0, a);
    check("post_rst_addr_ack", {7'b0, a}, 8'h00);
    wbyte(8'h07, a);
    check("post_rst_ptr_ack", {7'b0, a}, 8'h00);
    wbyte(8'h77, a);
    check("post_rst_data_ack", {7'b0, a}, 8'h00);
    stop_c();
    host_addr = 4'd7;
    wclk(1);
    check("post_rst_reg7", host_rdata, 8'h77);
    check("post_rst_state", {4'b0, state}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) controller that answers the team's I2C master on the shared SCL/SDA bus. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and serves a byte-wide register file through a pointer-then-data protocol. SDA is driven open-drain through `sda_drive_en`, so the block plugs directly into the existing bus and slave assertion monitors.

## Interface
- `TARGET_ADDR`, 7'h50, 7-bit bus address the block responds to.
- `NUM_REGS`, 16, register file depth; power of two, 2..256.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `scl` input 1: bus clock as seen on the wire.
- `sda` input 1: bus data as seen on the wire.
- `sda_drive_en` output 1: 1 = pull SDA low, 0 = release. The block never drives SDA high.
- `state` output 4: current FSM state, for the assertion bind.
- `busy` output 1: high from an address match until the next STOP or START.
- `host_addr` input log2(NUM_REGS): local read address into the register file.
- `host_rdata` output 8: combinational `reg[host_addr]`.

## Operation
- Input synchronizer: two flops each on `scl` and `sda`, plus one history flop for edge detection.
  - `scl_rise`, `scl_fall` and `sda` edges are computed on the synchronized signals.
- START is SDA falling while synced SCL is high. STOP is SDA rising while synced SCL is high.
  - Both are honoured in every state and take priority over bit handling in the same cycle.
  - START: go to ADDR, clear the bit counter, release SDA. Repeated START is handled the same way.
  - STOP: go to IDLE, release SDA, clear `busy`.
- FSM states (encoding):
  - IDLE=0
  - ADDR=1
  - ADDR_ACK=2
  - PTR=3
  - PTR_ACK=4
  - WDATA=5
  - WDATA_ACK=6
  - RDATA=7
  - RDATA_ACK=8
- Bits are sampled on `scl_rise`, MSB first, into an 8-bit shift register with a 3-bit counter. The 8th sample completes a byte.
- ADDR:
  - `byte[7:1] == TARGET_ADDR`: set `busy` and go to ADDR_ACK.
  - Otherwise go to IDLE with SDA released, which the master sees as a NACK. The block then ignores traffic until the next START.
- ACK states (ADDR_ACK, PTR_ACK, WDATA_ACK):
  - On the next `scl_fall`, assert `sda_drive_en`.
  - Hold it through the 9th `scl_rise`.
  - On the following `scl_fall`, release and move on.
- Exits from ADDR_ACK:
  - R/W bit = 0: go to PTR.
  - R/W bit = 1: go to RDATA. `sda_drive_en` is set to `~reg[ptr][7]` on that same fall.
- PTR: byte completes → `ptr <= byte mod NUM_REGS`, go to PTR_ACK, then WDATA.
- WDATA: byte completes → write `reg[ptr] <= byte`, `ptr <= ptr+1` (wraps NUM_REGS-1 → 0), go to WDATA_ACK, then back to WDATA.
- RDATA:
  - Each `scl_fall` presents the next bit: `sda_drive_en = ~bit`.
  - After the 8th bit's `scl_fall`, release SDA, set `ptr <= ptr+1` (wrap), and go to RDATA_ACK.
- RDATA_ACK: sample SDA on `scl_rise`.
  - 0 (ACK): on the next `scl_fall`, drive bit 7 of `reg[ptr]` and return to RDATA.
  - 1 (NACK): go to IDLE with SDA released; `busy` stays high until STOP/START.
- Register write and `host_addr` read are independent. A read of the register being written returns the old value in the write cycle and the new value after it.

## Timing
- Reset values:
  - `sda_drive_en=0`, `state=0`, `busy=0`
  - `ptr=0`, all registers `8'h00`, synchronizer flops 1
- Reset in mid-transfer returns to IDLE with SDA released on the next clock edge. The remaining bus traffic is ignored until a fresh START.
- Input-to-action latency is 3 `clk` cycles from a wire edge to the corresponding FSM update (2 sync + 1 edge).
  - `sda_drive_en` changes at most 4 `clk` after the wire SCL falls.
  - The master must keep SCL low for ≥ 6 `clk` and high for ≥ 4 `clk`.
- `sda_drive_en` changes only in the cycle after a `scl_fall`, or on START/STOP/reset. It never changes while synced SCL is high.
- Register write commits on the clock edge following the 8th `scl_rise` of a WDATA byte.

## Test plan
- Write to register: START, 0xA0, 0x03, 0xA5, STOP → ACK on all three bytes, `reg[3]=0xA5`, `host_rdata=0xA5` with `host_addr=3`, `state=0` after STOP.
- Pointer then read: START, 0xA0, 0x03, repeated START, 0xA1, read one byte, master NACK, STOP → SDA returns 0xA5. The slave releases SDA during the NACK bit and `ptr=4`.
- Address mismatch: START, 0x42 → SDA released on the 9th clock, `busy=0`, `state=0`. A following 0xA0 transaction after a new START is ACKed.
- Wrap-around: pointer 0x0F, write 0x11 then 0x22 (`NUM_REGS=16`) → `reg[15]=0x11`, `reg[0]=0x22`.
- Burst read with ACKs: pointer 0x0E, read 3 bytes with ACK, ACK, NACK → returns `reg[14]`, `reg[15]`, `reg[0]` in that order.
- Reset mid-write: assert `rst` for 1 clk during the 4th data bit → `sda_drive_en=0`, `state=0`, register unchanged. The next full transaction succeeds.
